sc_frame_integrator: RTL and testbench
======================================

Name: sc_frame_integrator

Overview:
- Downstream stage of the per-cycle popcount accumulator in the stochastic-computing datapath.
- Each cycle the accumulator produces a (K+1)-bit count of ones across N parallel bitstream lanes. This block integrates FRAMES such counts into one binary result.
- The result is the stochastic-to-binary conversion: value = result / (N*FRAMES).
- The result is delivered on a valid/ready handshake to the consumer.

Parameters:
- K, 3, log2 of lane count.
- N, 2**K, parallel bitstream lanes per beat; the maximum legal count_in.
- FRAMES, 16, accepted beats per frame (>=1).
- SUM_W, $clog2(N*FRAMES+1), result width (8 for the defaults).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a frame.
- abort  input  1  synchronous frame cancel.
- count_in  input  K+1  per-beat popcount from the accumulator.
- count_valid  input  1  count_in is a valid beat this cycle.
- result  output  SUM_W  integrated frame sum.
- result_valid  output  1  result is available.
- result_ready  input  1  consumer accepts result.
- busy  output  1  high in ACCUM.
- err  output  1  sticky flag: an out-of-range count was seen.

Behaviour:
- Reset (async, active-high): state=IDLE; acc, beat counter, result=0; result_valid=0, busy=0, err=0. A reset mid-frame discards the partial sum.
- States: IDLE, ACCUM, HOLD. State is encoded with the package enum.
- IDLE:
  - start=1 -> ACCUM next cycle, with acc=0 and beat=0.
  - count_valid is ignored in IDLE.
- ACCUM:
  - busy=1.
  - Each cycle with count_valid=1, add the clamped count to acc and increment beat. Cycles with count_valid=0 are bubbles and change nothing.
  - start is ignored in ACCUM.
- Last beat: when count_valid=1 and beat==FRAMES-1:
  - result <= acc + clamped count_in.
  - result_valid=1 and state=HOLD from the next cycle.
  - Latency is one cycle after the FRAMES-th accepted beat.
- Clamp rule:
  - count_in > N is clamped to N before the add.
  - err is set in the same cycle and stays high until reset.
  - Clamping applies only to beats accepted in ACCUM.
- HOLD:
  - result and result_valid are held stable until the cycle where result_ready=1.
  - On the handshake: result_valid drops next cycle and state -> IDLE.
  - If start=1 in the same cycle as the handshake: go directly to ACCUM with acc/beat cleared. There is no idle bubble.
  - count_valid is ignored in HOLD.
- abort:
  - Overrides every other input in any state.
  - Next state is IDLE with acc/beat cleared and result_valid=0.
  - result keeps its last value; err is unaffected.
  - abort in the same cycle as the last beat: abort wins and no result is produced.
- Width rules:
  - acc is SUM_W wide and cannot overflow, because the clamp bounds the total to N*FRAMES.
  - The beat counter is $clog2(FRAMES) bits, minimum 1.
  - FRAMES=1 is legal: every accepted beat completes a frame.
- result is zero-extended; no normalisation is done in this block.

Decomposition:
- Shared package sc_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - a function returning SUM_W from N and FRAMES;
  - the clamp function sat_count(count, N).
- One natural sub-module: sc_beat_counter, a FRAMES-modulo counter with clear, enable and last-beat flag. The FSM, accumulator and output register stay in the top.

Test Plan (K=3, N=8, FRAMES=16):
1. start, then 16 consecutive beats of count_in=8 -> result_valid rises one cycle after the 16th beat, result=128, err=0.
2. count_in=4 with count_valid toggling 1/0 (32 cycles) -> result=64 after the 16th valid beat; bubble cycles do not advance beat.
3. Complete a frame with result=40, hold result_ready=0 for 5 cycles -> result/result_valid stable. Then result_ready=1 together with start=1 -> busy=1 the next cycle and the new frame accumulates from 0.
4. One beat count_in=12, other 15 beats count_in=2 -> result=8+30=38, err=1 and still 1 after the next frame completes.
5. Assert reset asynchronously after 7 beats of 8 -> all outputs 0 immediately. Then start plus 16 beats of 1 -> result=16.
6. abort on the 16th beat with count_valid=1 -> no result_valid, state IDLE, busy=0. A later start plus 16 beats of 3 -> result=48.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing frame integrator.
//   sc_state_t : integrator FSM states (IDLE / ACCUM / HOLD)
//   sum_width  : result width able to hold N*FRAMES without overflow
//   sat_count  : clamps a per-beat popcount to the lane count N
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } sc_state_t;

    function automatic int sum_width(input int n, input int frames);
        return $clog2(n * frames + 1);
    endfunction

    // A popcount above the lane count can only come from an upstream fault;
    // pinning it to N keeps the frame total bounded by N*FRAMES.
    function automatic int unsigned sat_count(input int unsigned count,
                                              input int unsigned n);
        return (count > n) ? n : count;
    endfunction

endpackage

// File: rtl/sc_beat_counter.sv
// FRAMES-modulo beat counter.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : return to beat 0 (wins over enable)
//   enable     : count one accepted beat
//   last       : current beat is the final beat of the frame (FRAMES-1)
module sc_beat_counter #(
    parameter int FRAMES = 16,
    parameter int CNT_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [CNT_W-1:0] beat;

    // With FRAMES=1 the counter stays at 0, so every beat is the last one.
    assign last = (beat == CNT_W'(FRAMES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (enable) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/sc_frame_integrator.sv
// Integrates FRAMES per-beat popcounts from the N-lane accumulator into one
// binary result (value = result / (N*FRAMES)), delivered on valid/ready.
//   clk, reset    : clock and asynchronous active-high reset
//   start         : single-cycle request to begin a frame (IDLE, or HOLD on handshake)
//   abort         : synchronous frame cancel, overrides all other inputs
//   count_in      : per-beat popcount (0..N legal), qualified by count_valid
//   result        : integrated frame sum, held while result_valid
//   result_valid  : result available; result_ready completes the handshake
//   busy          : frame accumulation in progress
//   err           : sticky, an out-of-range count was accepted
module sc_frame_integrator
    import sc_pkg::*;
#(
    parameter int K      = 3,
    parameter int N      = 2 ** K,
    parameter int FRAMES = 16,
    parameter int SUM_W  = sum_width(N, FRAMES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [K:0]       count_in,
    input  logic             count_valid,
    output logic [SUM_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             err
);

    sc_state_t        state;
    logic [SUM_W-1:0] acc;
    logic [K:0]       clamped;
    logic             over;
    logic [SUM_W-1:0] sum_next;
    logic             accept;
    logic             begin_frame;
    logic             beat_last;

    assign over     = (32'(count_in) > 32'(N));
    assign clamped  = (K + 1)'(sat_count(32'(count_in), 32'(N)));
    assign sum_next = acc + SUM_W'(clamped);

    assign accept      = (state == ST_ACCUM) && count_valid && !abort;
    assign begin_frame = !abort && start &&
                         ((state == ST_IDLE) || ((state == ST_HOLD) && result_ready));

    sc_beat_counter #(
        .FRAMES (FRAMES)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (abort || begin_frame),
        .enable (accept),
        .last   (beat_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else if (abort) begin
            // result keeps its last value and err stays sticky.
            state        <= ST_IDLE;
            acc          <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (count_valid) begin
                        if (over) begin
                            err <= 1'b1;
                        end
                        if (beat_last) begin
                            result       <= sum_next;
                            result_valid <= 1'b1;
                            state        <= ST_HOLD;
                            busy         <= 1'b0;
                        end else begin
                            acc <= sum_next;
                        end
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        acc          <= '0;
                        // Back-to-back frames: start on the handshake skips IDLE.
                        if (start) begin
                            state <= ST_ACCUM;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_frame_integrator.sv
// Self-checking bench for sc_frame_integrator (K=3, N=8, FRAMES=16):
// directed frames with literal expectations plus randomized traffic, all
// checked every cycle against a frame-level behavioural model.
module tb_sc_frame_integrator;

    localparam int K      = 3;
    localparam int N      = 8;
    localparam int FRAMES = 16;
    localparam int SUM_W  = 8;

    logic             clk          = 1'b0;
    logic             reset        = 1'b1;
    logic             start        = 1'b0;
    logic             abort        = 1'b0;
    logic [K:0]       count_in     = '0;
    logic             count_valid  = 1'b0;
    logic             result_ready = 1'b0;
    logic [SUM_W-1:0] result;
    logic             result_valid;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sc_frame_integrator #(
        .K      (K),
        .N      (N),
        .FRAMES (FRAMES),
        .SUM_W  (SUM_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .count_in     (count_in),
        .count_valid  (count_valid),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .err          (err)
    );

    // Frame-level model: phase 0 = waiting, 1 = collecting beats, 2 = offering result.
    typedef struct packed {
        int ph;
        int sum;
        int beats;
        int res;
        bit rv;
        bit err;
    } m_t;

    m_t m;

    function automatic m_t step(input m_t c, input bit st, input bit ab,
                                input bit cv, input int cnt, input bit rdy);
        m_t n = c;
        if (ab) begin
            n.ph = 0; n.sum = 0; n.beats = 0; n.rv = 1'b0;
            return n;
        end
        if (c.ph == 0) begin
            if (st) begin
                n.ph = 1; n.sum = 0; n.beats = 0;
            end
        end else if (c.ph == 1) begin
            if (cv) begin
                if (cnt > N) n.err = 1'b1;
                n.sum   = c.sum + ((cnt > N) ? N : cnt);
                n.beats = c.beats + 1;
                if (n.beats == FRAMES) begin
                    n.res = n.sum; n.rv = 1'b1; n.ph = 2;
                end
            end
        end else begin
            if (rdy) begin
                n.rv = 1'b0; n.sum = 0; n.beats = 0;
                n.ph = st ? 1 : 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m, start, abort, count_valid, int'(count_in), result_ready);
    end

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_result", 32'(result), m.res);
            cmp("model_result_valid", 32'(result_valid), int'(m.rv));
            cmp("model_busy", 32'(busy), (m.ph == 1) ? 1 : 0);
            cmp("model_err", 32'(err), int'(m.err));
        end
    end

    task automatic drive(input bit st, input bit ab, input bit cv, input int cnt, input bit rdy);
        start        = st;
        abort        = ab;
        count_valid  = cv;
        count_in     = (K + 1)'(cnt);
        result_ready = rdy;
        @(negedge clk);
    endtask

    task automatic beats(input int n, input int cnt);
        repeat (n) drive(1'b0, 1'b0, 1'b1, cnt, 1'b0);
    endtask

    task automatic handshake();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp("reset_result", 32'(result), 0);
        cmp("reset_valid", 32'(result_valid), 0);
        cmp("reset_busy", 32'(busy), 0);
        cmp("reset_err", 32'(err), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8, 1'b0);
        cmp("idle_ignores_beats", 32'(busy), 0);

        // Full-scale frame
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cmp("t1_busy", 32'(busy), 1);
        beats(15, 8);
        cmp("t1_valid_early", 32'(result_valid), 0);
        beats(1, 8);
        cmp("t1_valid", 32'(result_valid), 1);
        cmp("t1_result", 32'(result), 128);
        cmp("t1_err", 32'(err), 0);
        cmp("t1_busy_hold", 32'(busy), 0);
        handshake();
        cmp("t1_valid_drop", 32'(result_valid), 0);

        // Bubbles between beats
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, (i % 2) == 0, 4, 1'b0);
            if (i == 29) cmp("t2_valid_early", 32'(result_valid), 0);
        end
        cmp("t2_valid", 32'(result_valid), 1);
        cmp("t2_result", 32'(result), 64);
        handshake();

        // Back-pressure, then handshake with start
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(8, 5);
        beats(8, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 7, 1'b0);
            cmp("t3_hold_result", 32'(result), 40);
            cmp("t3_hold_valid", 32'(result_valid), 1);
        end
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        cmp("t3_busy_b2b", 32'(busy), 1);
        cmp("t3_valid_drop", 32'(result_valid), 0);
        beats(16, 1);
        cmp("t3_new_result", 32'(result), 16);
        handshake();

        // Out-of-range count clamps and latches err
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(1, 12);
        cmp("t4_err_set", 32'(err), 1);
        beats(15, 2);
        cmp("t4_result", 32'(result), 38);
        handshake();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(16, 1);
        cmp("t4_result2", 32'(result), 16);
        cmp("t4_err_sticky", 32'(err), 1);
        handshake();

        // Asynchronous reset mid-frame
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(7, 8);
        #3 reset = 1'b1;
        #1;
        cmp("t5_async_result", 32'(result), 0);
        cmp("t5_async_valid", 32'(result_valid), 0);
        cmp("t5_async_busy", 32'(busy), 0);
        cmp("t5_async_err", 32'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(16, 1);
        cmp("t5_result", 32'(result), 16);
        handshake();

        // Abort on the last beat
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(15, 3);
        drive(1'b0, 1'b1, 1'b1, 3, 1'b0);
        cmp("t6_abort_valid", 32'(result_valid), 0);
        cmp("t6_abort_busy", 32'(busy), 0);
        cmp("t6_abort_result_kept", 32'(result), 16);
        drive(1'b0, 1'b0, 1'b1, 3, 1'b0);
        cmp("t6_idle_valid", 32'(result_valid), 0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        beats(16, 3);
        cmp("t6_result", 32'(result), 48);
        handshake();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit st, ab, cv, rdy;
            int cnt;
            st  = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 199) == 0);
            cv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 1) == 1);
            cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 8));
            drive(st, ab, cv, cnt, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
